// File: rtl/chi_xp_link_pkg.sv
// Shared types for the CHI XP link-layer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional feature macro used by the top: CHI_XP_LINK_TIMEOUT_EN.
// State encodings are Gray-coded so that the link request/ack outputs are a
// single state bit or a simple decode without multi-bit glitches.
package chi_xp_link_pkg;

    typedef enum logic [1:0] {
        TX_STOP  = 2'b00,
        TX_ACT   = 2'b01,
        TX_RUN   = 2'b11,
        TX_DEACT = 2'b10
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_STOP  = 2'b00,
        RX_ACT   = 2'b01,
        RX_RUN   = 2'b11,
        RX_DEACT = 2'b10
    } rx_state_e;

    // Channel index within every NUM_CH-wide vector.
    localparam int CH_REQ = 0;
    localparam int CH_RSP = 1;
    localparam int CH_DAT = 2;
    localparam int CH_SNP = 3;

endpackage

// File: rtl/chi_xp_crd_cnt.sv
// Saturating up/down credit counter with a same-cycle error flag.
// Latency: count updates on the clock edge after inc/dec; err is combinational.
// Backpressure: none; an over/underflow holds the count and raises err.
//
// Ports: clk, rst (async, active high), inc, dec, cnt[W], err.
// inc and dec together leave the count unchanged and never flag an error.
module chi_xp_crd_cnt #(
    parameter int W    = 4,
    parameter int MAX  = 15,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);

    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        err     = 1'b0;
        if (inc && !dec) begin
            if (cnt == W'(MAX)) err = 1'b1;
            else                cnt_nxt = cnt + W'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           cnt_nxt = cnt - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= W'(INIT);
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/chi_xp_link_ctrl.sv
// CHI link-layer controller for one XP port: TX/RX activation FSMs and credits.
// Latency: FSM outputs and RXLCRDV are one cycle after the causing input.
// Backpressure: tx_crd_avail gates flit issue per channel; RX grants stop when pool empties.
//
// Ports: clk/rst (async active high); link_en; TX/RX link-active handshake;
// TXSACTIVE; per-channel TXLCRDV, tx_flit_sent, tx_crd_avail, tx_crd_ret,
// RXFLITV, rx_buf_free, RXLCRDV; sticky link_err.
// Optional macro CHI_XP_LINK_TIMEOUT_EN adds handshake watchdogs feeding link_err.
module chi_xp_link_ctrl
    import chi_xp_link_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MAX_CRD     = 15,
    parameter int CRD_W       = 4,
    parameter int RX_CRD_INIT = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_en,
    output logic              TXLINKACTIVEREQ,
    input  logic              TXLINKACTIVEACK,
    input  logic              RXLINKACTIVEREQ,
    output logic              RXLINKACTIVEACK,
    output logic              TXSACTIVE,
    input  logic [NUM_CH-1:0] TXLCRDV,
    input  logic [NUM_CH-1:0] tx_flit_sent,
    output logic [NUM_CH-1:0] tx_crd_avail,
    output logic [NUM_CH-1:0] tx_crd_ret,
    input  logic [NUM_CH-1:0] RXFLITV,
    input  logic [NUM_CH-1:0] rx_buf_free,
    output logic [NUM_CH-1:0] RXLCRDV,
    output logic              link_err
);

    tx_state_e tx_q, tx_nxt;
    rx_state_e rx_q, rx_nxt;

    logic [CRD_W-1:0]  tx_cnt  [NUM_CH];
    logic [CRD_W-1:0]  rx_pool [NUM_CH];
    logic [CRD_W-1:0]  rx_out  [NUM_CH];
    logic [NUM_CH-1:0] tx_nz, out_nz, grant, tx_dec;
    logic [NUM_CH-1:0] tx_err, rx_out_err, rx_pool_err;
    logic              tmo_hit;

    // Per-channel credit bookkeeping.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign tx_nz[g]  = (tx_cnt[g] != '0);
        assign out_nz[g] = (rx_out[g] != '0);
        // A grant needs a free buffer and must not push the peer past MAX_CRD.
        assign grant[g]  = (rx_q == RX_RUN) && (rx_pool[g] != '0) &&
                           (rx_out[g] != CRD_W'(MAX_CRD));
        // Credits leave either by a normal flit or by an LCrdReturn in DEACT.
        assign tx_dec[g] = tx_flit_sent[g] | tx_crd_ret[g];

        chi_xp_crd_cnt #(.W(CRD_W), .MAX(MAX_CRD), .INIT(0)) u_tx_crd (
            .clk (clk), .rst (rst),
            .inc (TXLCRDV[g]), .dec (tx_dec[g]),
            .cnt (tx_cnt[g]),  .err (tx_err[g])
        );

        // Pool saturates at its reset size; a spare free is simply absorbed.
        chi_xp_crd_cnt #(.W(CRD_W), .MAX(RX_CRD_INIT), .INIT(RX_CRD_INIT)) u_rx_pool (
            .clk (clk), .rst (rst),
            .inc (rx_buf_free[g]), .dec (grant[g]),
            .cnt (rx_pool[g]),     .err (rx_pool_err[g])
        );

        chi_xp_crd_cnt #(.W(CRD_W), .MAX(MAX_CRD), .INIT(0)) u_rx_out (
            .clk (clk), .rst (rst),
            .inc (grant[g]),   .dec (RXFLITV[g]),
            .cnt (rx_out[g]),  .err (rx_out_err[g])
        );
    end

    // ---------------- TX link FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_q <= TX_STOP;
        else     tx_q <= tx_nxt;
    end

    always_comb begin
        tx_nxt = tx_q;
        case (tx_q)
            TX_STOP:  if (link_en) tx_nxt = TX_ACT;
            // A deactivation request while activating waits for the ack first.
            TX_ACT:   if (TXLINKACTIVEACK) tx_nxt = link_en ? TX_RUN : TX_DEACT;
            TX_RUN:   if (!link_en) tx_nxt = TX_DEACT;
            TX_DEACT: if (!TXLINKACTIVEACK && (tx_nz == '0)) tx_nxt = TX_STOP;
            default:  tx_nxt = TX_STOP;
        endcase
    end

    always_comb begin
        TXLINKACTIVEREQ = tx_q[0];  // set exactly in ACT and RUN
        TXSACTIVE       = (tx_q != TX_STOP);
        tx_crd_avail    = (tx_q == TX_RUN)   ? tx_nz : '0;
        tx_crd_ret      = (tx_q == TX_DEACT) ? tx_nz : '0;
    end

    // ---------------- RX link FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_q <= RX_STOP;
        else     rx_q <= rx_nxt;
    end

    always_comb begin
        rx_nxt = rx_q;
        case (rx_q)
            RX_STOP:  if (RXLINKACTIVEREQ) rx_nxt = RX_ACT;
            RX_ACT:   rx_nxt = RX_RUN;
            RX_RUN:   if (!RXLINKACTIVEREQ) rx_nxt = RX_DEACT;
            // Peer must hand back every outstanding credit before we stop.
            RX_DEACT: if (out_nz == '0) rx_nxt = RX_STOP;
            default:  rx_nxt = RX_STOP;
        endcase
    end

    always_comb begin
        RXLINKACTIVEACK = (rx_q != RX_STOP);
    end

    // Grants are counted on the same edge that raises RXLCRDV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) RXLCRDV <= '0;
        else     RXLCRDV <= grant;
    end

    // ---------------- Error reporting ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   link_err <= 1'b0;
        else if ((|tx_err) || (|rx_out_err) || tmo_hit) link_err <= 1'b1;
    end

    logic unused_sink;

`ifdef CHI_XP_LINK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tx_tmo, rx_tmo;

    // Each watchdog restarts on any state change and saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_tmo <= '0;
            rx_tmo <= '0;
        end else begin
            if ((tx_nxt != tx_q) || !((tx_q == TX_ACT) || (tx_q == TX_DEACT)))
                tx_tmo <= '0;
            else if (tx_tmo != TMO_W'(TIMEOUT_CYC))
                tx_tmo <= tx_tmo + TMO_W'(1);

            if ((rx_nxt != rx_q) || (rx_q != RX_DEACT))
                rx_tmo <= '0;
            else if (rx_tmo != TMO_W'(TIMEOUT_CYC))
                rx_tmo <= rx_tmo + TMO_W'(1);
        end
    end

    assign tmo_hit     = (tx_tmo == TMO_W'(TIMEOUT_CYC)) || (rx_tmo == TMO_W'(TIMEOUT_CYC));
    assign unused_sink = ^rx_pool_err;
`else
    assign tmo_hit     = 1'b0;
    // Pool saturation is benign, and the watchdog limit has no consumer here.
    assign unused_sink = ^{rx_pool_err, 32'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_chi_xp_link_ctrl.sv
// Directed self-checking bench for chi_xp_link_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_chi_xp_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en;
    logic       TXLINKACTIVEREQ, TXLINKACTIVEACK;
    logic       RXLINKACTIVEREQ, RXLINKACTIVEACK;
    logic       TXSACTIVE;
    logic [3:0] TXLCRDV, tx_flit_sent, tx_crd_avail, tx_crd_ret;
    logic [3:0] RXFLITV, rx_buf_free, RXLCRDV;
    logic       link_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chi_xp_link_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .link_en         (link_en),
        .TXLINKACTIVEREQ (TXLINKACTIVEREQ),
        .TXLINKACTIVEACK (TXLINKACTIVEACK),
        .RXLINKACTIVEREQ (RXLINKACTIVEREQ),
        .RXLINKACTIVEACK (RXLINKACTIVEACK),
        .TXSACTIVE       (TXSACTIVE),
        .TXLCRDV         (TXLCRDV),
        .tx_flit_sent    (tx_flit_sent),
        .tx_crd_avail    (tx_crd_avail),
        .tx_crd_ret      (tx_crd_ret),
        .RXFLITV         (RXFLITV),
        .rx_buf_free     (rx_buf_free),
        .RXLCRDV         (RXLCRDV),
        .link_err        (link_err)
    );

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         pulses;
        int         g0;
        int         gtot;
        logic [3:0] other;
        logic [3:0] gmask;

        rst = 1'b1; link_en = 1'b0;
        TXLINKACTIVEACK = 1'b0; RXLINKACTIVEREQ = 1'b0;
        TXLCRDV = '0; tx_flit_sent = '0; RXFLITV = '0; rx_buf_free = '0;
        repeat (3) step();

        // Reset state
        chk("rst_txreq",  32'(TXLINKACTIVEREQ), 32'd0);
        chk("rst_rxack",  32'(RXLINKACTIVEACK), 32'd0);
        chk("rst_sact",   32'(TXSACTIVE),       32'd0);
        chk("rst_err",    32'(link_err),        32'd0);
        chk("rst_rxlcrd", 32'(RXLCRDV),         32'd0);
        chk("rst_avail",  32'(tx_crd_avail),    32'd0);
        chk("rst_ret",    32'(tx_crd_ret),      32'd0);
        rst = 1'b0;

        // TX bring-up: REQ one cycle after link_en, credits gated until RUN
        link_en = 1'b1;
        step();
        chk("up_req",  32'(TXLINKACTIVEREQ), 32'd1);
        chk("up_sact", 32'(TXSACTIVE),       32'd1);
        TXLCRDV = 4'b0011;
        step();
        TXLCRDV = '0;
        chk("act_avail", 32'(tx_crd_avail), 32'h0);
        step();
        TXLINKACTIVEACK = 1'b1;
        step();
        chk("run_avail", 32'(tx_crd_avail), 32'h3);

        // Simultaneous credit and send on RSP leaves count at 1
        TXLCRDV = 4'b0010; tx_flit_sent = 4'b0010;
        repeat (3) step();
        TXLCRDV = '0; tx_flit_sent = '0;
        chk("simul_avail", 32'(tx_crd_avail), 32'h3);
        chk("simul_err",   32'(link_err),     32'd0);
        tx_flit_sent = 4'b0010;
        step();
        tx_flit_sent = '0;
        chk("simul_drain", 32'(tx_crd_avail), 32'h1);

        // RX bring-up: 4 grants per channel from the reset pool
        RXLINKACTIVEREQ = 1'b1;
        step();
        chk("rx_act_ack", 32'(RXLINKACTIVEACK), 32'd1);
        chk("rx_act_lcrd", 32'(RXLCRDV),        32'd0);
        step();
        g0 = 0; gtot = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (RXLCRDV[0]) g0++;
            gtot += $countones(RXLCRDV);
        end
        chk("rx_grants_ch0", 32'(g0),   32'd4);
        chk("rx_grants_tot", 32'(gtot), 32'd16);

        // One freed DAT buffer yields exactly one extra DAT grant
        rx_buf_free = 4'b0100;
        step();
        rx_buf_free = '0;
        gtot = 0; gmask = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            gtot += $countones(RXLCRDV);
            gmask |= RXLCRDV;
        end
        chk("rx_refill_cnt",  32'(gtot),  32'd1);
        chk("rx_refill_mask", 32'(gmask), 32'h4);

        // Bring outstanding down to 2 on every channel (DAT has 5, others 4)
        RXFLITV = 4'b1111;
        repeat (2) step();
        RXFLITV = 4'b0100;
        step();
        RXFLITV = '0;

        // RX deactivate: no grants in DEACT, stop once outstanding drains
        RXLINKACTIVEREQ = 1'b0;
        step();
        chk("rx_deact_ack", 32'(RXLINKACTIVEACK), 32'd1);
        rx_buf_free = 4'b1111;
        step();
        rx_buf_free = '0;
        gmask = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            gmask |= RXLCRDV;
        end
        chk("rx_deact_nogrant", 32'(gmask), 32'h0);
        RXFLITV = 4'b1111;
        step();
        chk("rx_deact_out1", 32'(RXLINKACTIVEACK), 32'd1);
        step();
        RXFLITV = '0;
        chk("rx_deact_out0", 32'(RXLINKACTIVEACK), 32'd1);
        step();
        chk("rx_stop_ack", 32'(RXLINKACTIVEACK), 32'd0);
        chk("rx_no_err",   32'(link_err),        32'd0);

        // TX deactivate with 3 DAT credits held
        tx_flit_sent = 4'b0001;
        step();
        tx_flit_sent = '0;
        TXLCRDV = 4'b0100;
        repeat (3) step();
        TXLCRDV = '0;
        chk("deact_pre_avail", 32'(tx_crd_avail), 32'h4);
        link_en = 1'b0;
        step();
        chk("deact_req",   32'(TXLINKACTIVEREQ), 32'd0);
        chk("deact_avail", 32'(tx_crd_avail),    32'h0);
        pulses = 0; other = '0;
        for (int i = 0; i < 6; i++) begin
            if (tx_crd_ret[2]) pulses++;
            other |= tx_crd_ret & 4'b1011;
            step();
        end
        chk("deact_ret_dat",   32'(pulses),    32'd3);
        chk("deact_ret_other", 32'(other),     32'h0);
        chk("deact_sact_hold", 32'(TXSACTIVE), 32'd1);
        TXLINKACTIVEACK = 1'b0;
        step();
        chk("tx_stop_sact", 32'(TXSACTIVE), 32'd0);
        chk("tx_stop_err",  32'(link_err),  32'd0);

        // Fresh link: credit overflow at MAX_CRD
        rst = 1'b1;
        step();
        rst = 1'b0;
        link_en = 1'b1; RXLINKACTIVEREQ = 1'b1;
        step();
        TXLINKACTIVEACK = 1'b1;
        step();
        TXLCRDV = 4'b0001;
        repeat (15) step();
        TXLCRDV = '0;
        chk("ovf_pre_err",   32'(link_err),     32'd0);
        chk("ovf_pre_avail", 32'(tx_crd_avail), 32'h1);
        TXLCRDV = 4'b0001;
        step();
        TXLCRDV = '0;
        chk("ovf_err", 32'(link_err), 32'd1);
        tx_flit_sent = 4'b0001;
        repeat (14) step();
        chk("ovf_14_avail", 32'(tx_crd_avail), 32'h1);
        step();
        tx_flit_sent = '0;
        chk("ovf_15_avail", 32'(tx_crd_avail), 32'h0);

        // Reset mid-RUN clears everything
        chk("pre_rst_req",   32'(TXLINKACTIVEREQ), 32'd1);
        chk("pre_rst_rxack", 32'(RXLINKACTIVEACK), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_outs",
            32'({TXLINKACTIVEREQ, RXLINKACTIVEACK, TXSACTIVE, link_err,
                 RXLCRDV, tx_crd_avail, tx_crd_ret}), 32'h0);
        link_en = 1'b0; RXLINKACTIVEREQ = 1'b0; TXLINKACTIVEACK = 1'b0;
        step();
        rst = 1'b0;

        // Flit with no outstanding credit is an error
        step();
        chk("uf_pre_err", 32'(link_err), 32'd0);
        RXFLITV = 4'b1000;
        step();
        RXFLITV = '0;
        chk("uf_err", 32'(link_err), 32'd1);

`ifdef CHI_XP_LINK_TIMEOUT_EN
        // Watchdog: ACK withheld in TX ACT
        rst = 1'b1;
        step();
        rst = 1'b0;
        link_en = 1'b1;
        repeat (1000) step();
        chk("tmo_early", 32'(link_err), 32'd0);
        repeat (30) step();
        chk("tmo_err", 32'(link_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
